// File: rtl/lights_out_pkg.sv
// Shared Lights Out definitions: board geometry, board vector type and
// the serial transmitter state encoding.
package lights_out_pkg;

  localparam int N_CELLS = 25;
  localparam int BOARD_W = N_CELLS;

  typedef logic [BOARD_W-1:0] board_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HIGH,
    LATCH
  } tx_state_t;

endpackage

// File: rtl/lights_out_board_tx.sv
// Shifts the board state MSB first into a 74HC595-style LED chain
// (sclk/sdata/latch), one frame per accepted start request.
module lights_out_board_tx
  import lights_out_pkg::*;
#(
  parameter int N_BITS  = 25,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BITS-1:0] board,
  input  logic              start,
  output logic              ready,
  output logic              done,
  output logic              sclk,
  output logic              sdata,
  output logic              latch
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int IDX_W = $clog2(N_BITS) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(N_BITS - 1);

  tx_state_t         state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N_BITS-1:0] shadow_q, shadow_d;
  logic              ready_d, done_d, sclk_d, sdata_d, latch_d;
  logic [IDX_W-1:0]  next_idx;
  logic              next_bit;
  logic              div_last;

  assign div_last = (div_q == DIV_LAST);

  // Bit that goes onto sdata when the current sclk high phase ends.
  always_comb begin
    next_idx = idx_q - IDX_W'(1);
    next_bit = 1'b0;
    for (int i = 0; i < N_BITS; i++) begin
      if (next_idx == IDX_W'(i)) next_bit = shadow_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    ready_d  = ready;
    done_d   = 1'b0;
    sclk_d   = sclk;
    sdata_d  = sdata;
    latch_d  = latch;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        sclk_d  = 1'b0;
        latch_d = 1'b0;
        if (start && ready) begin
          shadow_d = board;
          idx_d    = IDX_TOP;
          div_d    = '0;
          sdata_d  = board[N_BITS-1];
          ready_d  = 1'b0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (div_last) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = HIGH;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      HIGH: begin
        if (div_last) begin
          div_d  = '0;
          sclk_d = 1'b0;
          // Data changes on the same edge as the sclk fall.
          if (idx_q == '0) begin
            latch_d = 1'b1;
            sdata_d = 1'b0;
            state_d = LATCH;
          end else begin
            idx_d   = next_idx;
            sdata_d = next_bit;
            state_d = SETUP;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      LATCH: begin
        sclk_d = 1'b0;
        if (div_last) begin
          div_d   = '0;
          latch_d = 1'b0;
          ready_d = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      sclk     <= 1'b0;
      sdata    <= 1'b0;
      latch    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      ready    <= ready_d;
      done     <= done_d;
      sclk     <= sclk_d;
      sdata    <= sdata_d;
      latch    <= latch_d;
    end
  end

endmodule

// File: doc/lights_out_board_tx.md
# lights_out_board_tx

Serial transmitter that sends the 5×5 Lights Out board state to an external shift-register LED chain (74HC595-style: clock, data, latch). It sits between the game core, which presents a 25-bit board vector, and the dedicated outputs. It is the outbound counterpart to the button-input path. One frame is sent per accepted request: MSB first, followed by a latch strobe.

## Interface
- `N_BITS`, default 25: board bits per frame (cell index = row*5+col); must be ≥1.
- `CLK_DIV`, default 4: system clocks per SCLK half-period; must be ≥1.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `board`  in  N_BITS  board state; bit set = light on; sampled only on acceptance.
- `start`  in  1  frame request.
- `ready`  out  1  high in IDLE; a frame is accepted when `start & ready` at a clock edge.
- `done`  out  1  one-cycle pulse on the cycle the transmitter returns to IDLE.
- `sclk`  out  1  shift clock to the chain; the chain samples on its rising edge.
- `sdata`  out  1  serial data.
- `latch`  out  1  storage-register strobe, active-high.

## Operation
- All outputs are registered. Reset values: `ready`=1, `done`=0, `sclk`=0, `sdata`=0, `latch`=0. State resets to IDLE, and the counters and shadow register reset to 0.
- States: IDLE, SETUP, HIGH, LATCH.
- **IDLE:** `ready`=1, `sclk`=0, `latch`=0. On `start & ready`:
  - `shadow <= board`, `bit_idx <= N_BITS-1`, `div <= 0`, `sdata <= board[N_BITS-1]`.
  - `ready <= 0`, go to SETUP.
- **SETUP:** `sclk`=0 and `sdata` is held. `div` counts 0..CLK_DIV-1. At `div==CLK_DIV-1`: `div <= 0`, `sclk <= 1`, go to HIGH.
- **HIGH:** `sclk`=1. At `div==CLK_DIV-1`: `div <= 0`, `sclk <= 0`, then:
  - if `bit_idx==0`: `latch <= 1`, `sdata <= 0`, go to LATCH;
  - otherwise: `bit_idx <= bit_idx-1`, `sdata <= shadow[bit_idx-1]`, go to SETUP.
- **LATCH:** `latch`=1, `sclk`=0. At `div==CLK_DIV-1`: `latch <= 0`, `ready <= 1`, `done <= 1`, go to IDLE.
- `done` is cleared on the following cycle.
- `start` outside IDLE is ignored; requests are not queued.
- Changes to `board` during a frame do not affect it; only `shadow` is shifted.
- Back-to-back frames: `start` held high in the cycle where `ready` is high is accepted immediately. That cycle may coincide with the `done` pulse.
- Reset mid-frame: all outputs return to reset values asynchronously and the frame is abandoned; no partial latch is issued.
- Counter widths: `div` uses $clog2(CLK_DIV)+1 bits and `bit_idx` uses $clog2(N_BITS)+1 bits. Neither wraps, since both are compared for equality before incrementing or decrementing.

## Timing
- Acceptance edge E0. `sdata` presents bit N_BITS-1 after E0.
- The first `sclk` rise is CLK_DIV cycles after E0. Data setup before each rise is CLK_DIV cycles. Data hold after each fall is 0 cycles, since data changes on the same edge as the fall.
- `sclk` period is 2*CLK_DIV cycles; exactly N_BITS rising edges per frame.
- `latch` is high for CLK_DIV cycles, starting on the edge where the last `sclk` falls.
- Busy time (`ready` low) is 2*N_BITS*CLK_DIV + CLK_DIV cycles: 204 cycles for the defaults.
- `done` is asserted in the first cycle `ready` is high again.
- With CLK_DIV=1, SETUP, HIGH and LATCH each last exactly 1 cycle.

## Structure
- Shared package `lights_out_pkg` holds:
  - `N_CELLS`=25 and `BOARD_W`=N_CELLS;
  - the `board_t` typedef (logic [BOARD_W-1:0]);
  - the `tx_state_t` enum {IDLE, SETUP, HIGH, LATCH}.
- Single module. The divider and bit counter are inline; no sub-module is warranted at this size.

## Test plan
- **Reset:** assert `rst` for 3 cycles, then release. Required: `ready`=1 and `sclk`/`sdata`/`latch`/`done`=0; hold 10 idle cycles with no `sclk` edges.
- **Single frame, CLK_DIV=1:** `board`=25'h1555555 with a `start` pulse. Required:
  - the bit stream sampled on `sclk` rises is 1,0,1,…,1 (25 bits, MSB first);
  - `latch` is high for 1 cycle;
  - `done` pulses 51 cycles after acceptance.
- **Default CLK_DIV=4:** `board`=25'h0000001. Required:
  - 24 zeros, then a 1;
  - `sclk` high and low phases of 4 cycles each;
  - `ready` low for exactly 204 cycles.
- **Ignored start / board isolation:** pulse `start` and change `board` to 25'h1FFFFFF mid-frame. Required: the original frame is unchanged and no second frame follows.
- **Back-to-back:** hold `start` high continuously with `board`=25'h0AAAAAA. Required: the second frame is accepted on the `done` cycle with zero idle gap, and both frames are identical.
- **Reset mid-frame:** assert `rst` after 10 `sclk` rises. Required: immediate return to reset values, `latch` never asserted, and a fresh `start` then sends a full 25-bit frame.
